// File: rtl/mic1_pkg.sv
// Shared MIC-1 fetch definitions: fetch state encoding, MBR width, default timeout
// and the byte extend helpers also used by the datapath B-bus mux.
package mic1_pkg;

  localparam int MBR_W                   = 8;
  localparam int MBR_ERR_TIMEOUT_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT    = 3'd2,
    PF_REQ  = 3'd3,
    PF_WAIT = 3'd4
  } fetch_state_e;

  function automatic logic [31:0] mbr_sext8(input logic [MBR_W-1:0] b);
    return {{(32-MBR_W){b[MBR_W-1]}}, b};
  endfunction

  function automatic logic [31:0] mbr_zext8(input logic [MBR_W-1:0] b);
    return {{(32-MBR_W){1'b0}}, b};
  endfunction

endpackage

// File: rtl/mbr_prefetch_buf.sv
// One-entry prefetch buffer (valid/address/data) with the hit compare against a lookup
// address. Only instantiated when MBR_FETCH_PREFETCH_EN is defined.
module mbr_prefetch_buf
  import mic1_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill,
  input  logic              inval,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [MBR_W-1:0]  fill_data,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [MBR_W-1:0]  pf_data
);

  logic              pf_valid_q, pf_valid_d;
  logic [ADDR_W-1:0] pf_addr_q, pf_addr_d;
  logic [MBR_W-1:0]  pf_data_q, pf_data_d;

  always_comb begin
    pf_valid_d = pf_valid_q;
    pf_addr_d  = pf_addr_q;
    pf_data_d  = pf_data_q;
    if (inval) begin
      pf_valid_d = 1'b0;
    end else if (fill) begin
      pf_valid_d = 1'b1;
      pf_addr_d  = fill_addr;
      pf_data_d  = fill_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pf_valid_q <= 1'b0;
    else     pf_valid_q <= pf_valid_d;
  end

  // Address/data are only meaningful while pf_valid_q is set, so they carry no reset.
  always_ff @(posedge clk) begin
    pf_addr_q <= pf_addr_d;
    pf_data_q <= pf_data_d;
  end

  assign hit     = pf_valid_q && (lookup_addr == pf_addr_q);
  assign pf_data = pf_data_q;

endmodule

// File: rtl/mbr_fetch_unit.sv
// MBR byte-fetch engine: req/gnt/rvalid read of one byte per MIR fetch, with WAIT timeout.
// Define MBR_FETCH_PREFETCH_EN to add the next-byte prefetch buffer.
module mbr_fetch_unit
  import mic1_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = MBR_ERR_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch,
  input  logic [ADDR_W-1:0] pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [MBR_W-1:0]  mem_rdata,
  output logic [MBR_W-1:0]  mbr,
  output logic [31:0]       mbr_sext,
  output logic [31:0]       mbr_zext,
  output logic              mbr_valid,
  output logic              busy,
  output logic              err
);

  localparam int              CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit              TO_EN    = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [MBR_W-1:0]  mbr_q, mbr_d;
  logic              vld_q, vld_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_hit;

  assign timeout_hit = TO_EN && (cnt_q == CNT_LAST);

`ifdef MBR_FETCH_PREFETCH_EN
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              merge_q, merge_d;
  logic              pf_fill, pf_inval, pf_hit;
  logic [MBR_W-1:0]  pf_data;
  logic              take_fetch, want_merge, want_pend;
  logic [ADDR_W-1:0] pend_tgt;

  mbr_prefetch_buf #(.ADDR_W(ADDR_W)) u_pf_buf (
    .clk         (clk),
    .rst         (rst),
    .fill        (pf_fill),
    .inval       (pf_inval),
    .fill_addr   (addr_q),
    .fill_data   (mem_rdata),
    .lookup_addr (pc),
    .hit         (pf_hit),
    .pf_data     (pf_data)
  );

  // A fetch arriving during a prefetch either merges with it (same byte) or waits behind it.
  assign take_fetch = fetch && !pend_q && !merge_q;
  assign want_merge = merge_q || (take_fetch && (pc == addr_q));
  assign want_pend  = pend_q || (take_fetch && (pc != addr_q));
  assign pend_tgt   = pend_q ? pend_addr_q : pc;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mbr_d   = mbr_q;
    vld_d   = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
`ifdef MBR_FETCH_PREFETCH_EN
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    merge_d     = merge_q;
    pf_fill     = 1'b0;
    pf_inval    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (fetch) begin
`ifdef MBR_FETCH_PREFETCH_EN
          if (pf_hit) begin
            mbr_d    = pf_data;
            vld_d    = 1'b1;
            addr_d   = pc + ADDR_W'(1);
            pf_inval = 1'b1;
            state_d  = PF_REQ;
          end else begin
            addr_d  = pc;
            state_d = REQ;
          end
`else
          addr_d  = pc;
          state_d = REQ;
`endif
        end
      end
      REQ: begin
        if (mem_gnt) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          mbr_d = mem_rdata;
          vld_d = 1'b1;
`ifdef MBR_FETCH_PREFETCH_EN
          addr_d   = addr_q + ADDR_W'(1);
          pf_inval = 1'b1;
          state_d  = PF_REQ;
`else
          state_d = IDLE;
`endif
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef MBR_FETCH_PREFETCH_EN
      PF_REQ: begin
        merge_d     = want_merge;
        pend_d      = want_pend;
        pend_addr_d = pend_tgt;
        if (mem_gnt) begin
          state_d = PF_WAIT;
          cnt_d   = '0;
        end
      end
      PF_WAIT: begin
        merge_d     = want_merge;
        pend_d      = want_pend;
        pend_addr_d = pend_tgt;
        if (mem_rvalid) begin
          merge_d = 1'b0;
          pend_d  = 1'b0;
          if (want_merge) begin
            mbr_d   = mem_rdata;
            vld_d   = 1'b1;
            addr_d  = addr_q + ADDR_W'(1);
            state_d = PF_REQ;
          end else if (want_pend) begin
            addr_d  = pend_tgt;
            state_d = REQ;
          end else begin
            pf_fill = 1'b1;
            state_d = IDLE;
          end
        end else if (timeout_hit) begin
          // A merged demand fetch that times out is a real fetch failure; a bare prefetch is not.
          merge_d = 1'b0;
          pend_d  = 1'b0;
          if (want_merge) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (want_pend) begin
            addr_d  = pend_tgt;
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      mbr_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mbr_q   <= mbr_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MBR_FETCH_PREFETCH_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= 1'b0;
      merge_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      merge_q <= merge_d;
    end
  end

  always_ff @(posedge clk) begin
    pend_addr_q <= pend_addr_d;
  end

  assign mem_req = (state_q == REQ) || (state_q == PF_REQ);
  assign busy    = (state_q == REQ) || (state_q == WAIT) || pend_q || merge_q;
`else
  assign mem_req = (state_q == REQ);
  assign busy    = (state_q != IDLE);
`endif

  assign mem_addr  = addr_q;
  assign mbr       = mbr_q;
  assign mbr_sext  = mbr_sext8(mbr_q);
  assign mbr_zext  = mbr_zext8(mbr_q);
  assign mbr_valid = vld_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mbr_fetch_unit.sv
// Directed bench for mbr_fetch_unit (default build): a transaction-level model is
// compared every cycle, plus hand-computed literal checks after each scenario.
module tb_mbr_fetch_unit;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk;
  logic              rst;
  logic              fetch;
  logic [ADDR_W-1:0] pc;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [7:0]        mem_rdata;
  logic [7:0]        mbr;
  logic [31:0]       mbr_sext;
  logic [31:0]       mbr_zext;
  logic              mbr_valid;
  logic              busy;
  logic              err;

  mbr_fetch_unit #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch      (fetch),
    .pc         (pc),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mbr        (mbr),
    .mbr_sext   (mbr_sext),
    .mbr_zext   (mbr_zext),
    .mbr_valid  (mbr_valid),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchecks = 0;
  int nerrors = 0;
  bit chk_en  = 1'b0;
  int busy_cnt, valid_cnt, req_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: one outstanding fetch, tracked as "accepted / granted / cycles waited for data".
  bit          m_busy, m_granted, m_pulse, m_err;
  logic [31:0] m_addr;
  logic [7:0]  m_mbr;
  int          m_waited;

  always @(posedge clk) begin
    m_pulse = 1'b0;
    if (rst) begin
      m_busy = 0; m_granted = 0; m_err = 0; m_addr = '0; m_mbr = '0; m_waited = 0;
    end else if (!m_busy) begin
      if (fetch) begin
        m_busy = 1; m_granted = 0; m_addr = pc;
      end
    end else if (!m_granted) begin
      if (mem_gnt) begin
        m_granted = 1; m_waited = 0;
      end
    end else if (mem_rvalid) begin
      m_mbr = mem_rdata; m_pulse = 1; m_busy = 0;
    end else begin
      m_waited++;
      if (m_waited == TIMEOUT) begin
        m_err = 1; m_busy = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",      32'(busy),      32'(m_busy));
      check("mem_req",   32'(mem_req),   32'(m_busy && !m_granted));
      check("mem_addr",  mem_addr,       m_addr);
      check("mbr",       32'(mbr),       32'(m_mbr));
      check("mbr_sext",  mbr_sext,       {{24{m_mbr[7]}}, m_mbr});
      check("mbr_zext",  mbr_zext,       {24'd0, m_mbr});
      check("mbr_valid", 32'(mbr_valid), 32'(m_pulse));
      check("err",       32'(err),       32'(m_err));
      if (busy)      busy_cnt++;
      if (mbr_valid) valid_cnt++;
      if (mem_req)   req_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    busy_cnt = 0; valid_cnt = 0; req_cnt = 0;
  endtask

  // Issue one fetch; optionally pulse a second fetch (pc=0x20) during the grant wait.
  task automatic do_fetch(input logic [31:0] a, input int gnt_dly, input int rv_dly,
                          input logic [7:0] d, input bit busy_pulse);
    fetch = 1'b1; pc = a;
    step();
    fetch = 1'b0;
    for (int i = 0; i < gnt_dly; i++) begin
      if (busy_pulse && i == 0) begin
        fetch = 1'b1; pc = 32'h20;
      end
      step();
      fetch = 1'b0;
    end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    for (int i = 0; i < rv_dly; i++) step();
    mem_rvalid = 1'b1; mem_rdata = d;
    step();
    mem_rvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fetch = 1'b0; pc = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    clear_counts();
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    check("reset_mbr",   32'(mbr),       32'h0);
    check("reset_busy",  32'(busy),      32'h0);
    check("reset_req",   32'(mem_req),   32'h0);
    check("reset_addr",  mem_addr,       32'h0);
    check("reset_err",   32'(err),       32'h0);
    check("reset_valid", 32'(mbr_valid), 32'h0);

    // Minimum latency fetch.
    clear_counts();
    do_fetch(32'h10, 0, 0, 8'hA5, 1'b0);
    step();
    check("t1_mbr",       32'(mbr),  32'hA5);
    check("t1_sext",      mbr_sext,  32'hFFFFFFA5);
    check("t1_zext",      mbr_zext,  32'h000000A5);
    check("t1_valid_cnt", valid_cnt, 1);
    check("t1_busy_cnt",  busy_cnt,  2);

    // Grant delayed 3 cycles with a fetch pulse (pc=0x20) while busy.
    clear_counts();
    do_fetch(32'h10, 3, 0, 8'h7F, 1'b1);
    step();
    check("t2_addr",    mem_addr, 32'h10);
    check("t2_mbr",     32'(mbr), 32'h7F);
    check("t2_sext",    mbr_sext, 32'h0000007F);
    check("t2_req_cnt", req_cnt,  4);
    check("t2_busy",    32'(busy), 32'h0);

    // No read data: timeout after 16 cycles in WAIT.
    clear_counts();
    fetch = 1'b1; pc = 32'h50;
    step();
    fetch = 1'b0; mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    repeat (20) step();
    check("t3_err",       32'(err),  32'h1);
    check("t3_busy",      32'(busy), 32'h0);
    check("t3_mbr",       32'(mbr),  32'h7F);
    check("t3_valid_cnt", valid_cnt, 0);
    do_fetch(32'h60, 1, 2, 8'h80, 1'b0);
    step();
    check("t3_next_mbr",  32'(mbr),  32'h80);
    check("t3_next_sext", mbr_sext,  32'hFFFFFF80);
    check("t3_err_stick", 32'(err),  32'h1);

    // Reset while in WAIT; a late rvalid must be ignored.
    fetch = 1'b1; pc = 32'h70;
    step();
    fetch = 1'b0; mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    mem_rvalid = 1'b1; mem_rdata = 8'h5A;
    step();
    mem_rvalid = 1'b0;
    step();
    check("t4_mbr",  32'(mbr),  32'h0);
    check("t4_busy", 32'(busy), 32'h0);
    check("t4_err",  32'(err),  32'h0);
    check("t4_addr", mem_addr,  32'h0);

    // gnt and rvalid at the same edge in REQ: only the grant counts.
    fetch = 1'b1; pc = 32'h84;
    step();
    fetch = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 8'h33;
    step();
    mem_gnt = 1'b0; mem_rdata = 8'h44;
    step();
    mem_rvalid = 1'b0;
    step();
    check("t5_mbr", 32'(mbr), 32'h44);

    // fetch and rvalid at the same edge in WAIT: the new fetch is dropped.
    fetch = 1'b1; pc = 32'h90;
    step();
    fetch = 1'b0; mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 8'hC3; fetch = 1'b1; pc = 32'h99;
    step();
    mem_rvalid = 1'b0; fetch = 1'b0;
    step();
    check("t6_busy", 32'(busy),    32'h0);
    check("t6_req",  32'(mem_req), 32'h0);
    check("t6_addr", mem_addr,     32'h90);
    check("t6_mbr",  32'(mbr),     32'hC3);

    // Top-of-range address.
    do_fetch(32'hFFFF_FFFF, 0, 1, 8'h01, 1'b0);
    step();
    check("t7_addr", mem_addr, 32'hFFFF_FFFF);
    check("t7_mbr",  32'(mbr), 32'h01);

    repeat (3) step();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
